// File: rtl/slc3_mc_core_if.sv
// slc3_mc_core_if - memory port of the multi-cycle SLC-3 core.
//   mem_rdata   16      read data, valid while mem_ready=1
//   mem_ready   1       access completes in the current cycle
//   mem_wdata   16      write data (core MDR)
//   mem_addr    ADDR_W  access address (core MAR low bits)
//   mem_mem_ena 1       access request, held until mem_ready
//   mem_wr_ena  1       write qualifier, only together with mem_mem_ena
// master = core side, slave = memory/IO side.
interface slc3_mc_core_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [15:0]       mem_rdata;
  logic              mem_ready;
  logic [15:0]       mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_mem_ena;
  logic              mem_wr_ena;

  modport master (
    input  mem_rdata, mem_ready,
    output mem_wdata, mem_addr, mem_mem_ena, mem_wr_ena
  );

  modport slave (
    output mem_rdata, mem_ready,
    input  mem_wdata, mem_addr, mem_mem_ena, mem_wr_ena
  );
endinterface

// File: rtl/slc3_mc_core.sv
// slc3_mc_core - multi-cycle SLC-3 core (fetch/decode/execute FSM,
// 8x16 register file, N/Z/P condition codes, branch enable) on a
// variable-latency memory port with a ready handshake.
//   clk               system clock, all state on rising edge
//   reset             synchronous, active-low
//   run_i             level; leaves HALT
//   continue_i        rising edge leaves PAUSE
//   mem               memory port (master side)
//   hex_display_debug current IR
//   led_o             {4'b0, IR[11:0]} while paused, else 0
//   halted_o          1 while in HALT
module slc3_mc_core #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int unsigned ADDR_W   = 16,
  parameter bit          PAUSE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 continue_i,
  slc3_mc_core_if.master       mem,
  output logic [15:0]          hex_display_debug,
  output logic [15:0]          led_o,
  output logic                 halted_o
);

  typedef enum logic [3:0] {
    S_HALT, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC,
    S_LDR_ADDR, S_LDR_READ, S_LDR_LOAD,
    S_STR_ADDR, S_STR_DATA, S_STR_WRITE, S_PAUSE
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        ben_q, ben_d;
  logic        n_q, z_q, p_q;
  logic        cont_q;
  logic [15:0] regs_q [8];

  // single register-file write port; cc_we also refreshes N/Z/P from wr_data
  logic        wr_en, cc_we;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  logic [3:0]  opcode;
  logic [15:0] sr1_val, op2, alu, ea;
  logic        cont_rise;

  assign opcode    = ir_q[15:12];
  assign sr1_val   = regs_q[ir_q[8:6]];
  assign op2       = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : regs_q[ir_q[2:0]];
  assign ea        = sr1_val + {{10{ir_q[5]}}, ir_q[5:0]};
  // cont_q holds last cycle's continue_i and resets to 1, so a level that is
  // already high when PAUSE is entered never counts as a press
  assign cont_rise = continue_i & ~cont_q;

  always_comb begin
    alu = ~sr1_val;
    case (opcode)
      OP_ADD:  alu = sr1_val + op2;
      OP_AND:  alu = sr1_val & op2;
      default: alu = ~sr1_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ben_d   = ben_q;
    wr_en   = 1'b0;
    cc_we   = 1'b0;
    wr_addr = ir_q[11:9];
    wr_data = alu;
    case (state_q)
      S_HALT:   if (run_i) state_d = S_FETCH1;
      S_FETCH1: begin
        mar_d   = pc_q;
        pc_d    = pc_q + 16'd1;
        state_d = S_FETCH2;
      end
      S_FETCH2: if (mem.mem_ready) begin
        mdr_d   = mem.mem_rdata;
        state_d = S_FETCH3;
      end
      S_FETCH3: begin
        ir_d    = mdr_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ben_d = (n_q & ir_q[11]) | (z_q & ir_q[10]) | (p_q & ir_q[9]);
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR: state_d = S_EXEC;
          OP_LDR:  state_d = S_LDR_ADDR;
          OP_STR:  state_d = S_STR_ADDR;
          OP_PSE:  state_d = PAUSE_EN ? S_PAUSE : S_FETCH1;
          default: state_d = S_FETCH1;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            wr_en = 1'b1;
            cc_we = 1'b1;
          end
          OP_BR:  if (ben_q) pc_d = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
          OP_JMP: pc_d = sr1_val;
          OP_JSR: begin
            wr_en   = 1'b1;
            wr_addr = 3'd7;
            wr_data = pc_q;
            pc_d    = pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
          end
          default: ;
        endcase
        state_d = S_FETCH1;
      end
      S_LDR_ADDR: begin
        mar_d   = ea;
        state_d = S_LDR_READ;
      end
      S_LDR_READ: if (mem.mem_ready) begin
        mdr_d   = mem.mem_rdata;
        state_d = S_LDR_LOAD;
      end
      S_LDR_LOAD: begin
        wr_en   = 1'b1;
        cc_we   = 1'b1;
        wr_data = mdr_q;
        state_d = S_FETCH1;
      end
      S_STR_ADDR: begin
        mar_d   = ea;
        state_d = S_STR_DATA;
      end
      S_STR_DATA: begin
        mdr_d   = regs_q[ir_q[11:9]];
        state_d = S_STR_WRITE;
      end
      S_STR_WRITE: if (mem.mem_ready) state_d = S_FETCH1;
      S_PAUSE:     if (cont_rise) state_d = S_FETCH1;
      default:     state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_HALT;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      ben_q   <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      p_q     <= 1'b0;
      cont_q  <= 1'b1;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ben_q   <= ben_d;
      cont_q  <= continue_i;
      if (wr_en) regs_q[wr_addr] <= wr_data;
      if (cc_we) begin
        n_q <= wr_data[15];
        z_q <= (wr_data == 16'h0000);
        p_q <= ~wr_data[15] & (wr_data != 16'h0000);
      end
    end
  end

  assign mem.mem_mem_ena  = (state_q == S_FETCH2) || (state_q == S_LDR_READ) ||
                            (state_q == S_STR_WRITE);
  assign mem.mem_wr_ena   = (state_q == S_STR_WRITE);
  assign mem.mem_addr     = mar_q[ADDR_W-1:0];
  assign mem.mem_wdata    = mdr_q;
  assign hex_display_debug = ir_q;
  assign led_o            = (state_q == S_PAUSE) ? {4'b0000, ir_q[11:0]} : 16'h0000;
  assign halted_o         = (state_q == S_HALT);

endmodule

// File: tb/tb_slc3_mc_core.sv
module tb_slc3_mc_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        run_i;
  logic        continue_i;
  logic [15:0] hex_display_debug;
  logic [15:0] led_o;
  logic        halted_o;

  int n_tests = 0;
  int n_fail  = 0;

  slc3_mc_core_if #(.ADDR_W(16)) bus ();

  slc3_mc_core #(
    .PC_RESET (16'h0020),
    .ADDR_W   (16),
    .PAUSE_EN (1'b1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .run_i             (run_i),
    .continue_i        (continue_i),
    .mem               (bus.master),
    .hex_display_debug (hex_display_debug),
    .led_o             (led_o),
    .halted_o          (halted_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [15:0] mem_arr [0:65535];
  assign bus.mem_rdata = mem_arr[bus.mem_addr];

  function automatic int wait_of(input logic [15:0] a);
    if (a == 16'h0042) return 1000;
    if ((a >= 16'h0029 && a <= 16'h002D) || a == 16'h0040 || a == 16'h0041) return 3;
    return 0;
  endfunction

  int          cyc = 0;
  logic        rst_edge = 1'b0;
  int          wcnt = 0;
  logic        ena_prev = 1'b0;
  logic        done_prev = 1'b0;
  int          hold_viol = 0;
  int          wr_viol = 0;
  logic [15:0] acc_addr [$];
  int          fetch_at [int];
  logic [15:0] fetch_hex [int];
  logic [15:0] w_addr [$];
  logic [15:0] w_data [$];

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset;
    if (reset && bus.mem_mem_ena && bus.mem_wr_ena && bus.mem_ready) begin
      mem_arr[bus.mem_addr] <= bus.mem_wdata;
      w_addr.push_back(bus.mem_addr);
      w_data.push_back(bus.mem_wdata);
    end
  end

  always @(negedge clk) begin
    if (!bus.mem_mem_ena) begin
      wcnt = 0;
      bus.mem_ready = 1'b0;
    end else if (wcnt >= wait_of(bus.mem_addr)) begin
      bus.mem_ready = 1'b1;
    end else begin
      bus.mem_ready = 1'b0;
      wcnt++;
    end
    if (ena_prev && !done_prev && !bus.mem_mem_ena && rst_edge) hold_viol++;
    if (bus.mem_wr_ena && !bus.mem_mem_ena) wr_viol++;
    if (bus.mem_mem_ena && !ena_prev) begin
      acc_addr.push_back(bus.mem_addr);
      if (!bus.mem_wr_ena) begin
        fetch_at[int'(bus.mem_addr)]  = cyc;
        fetch_hex[int'(bus.mem_addr)] = hex_display_debug;
      end
    end
    done_prev = bus.mem_mem_ena && bus.mem_ready;
    ena_prev  = bus.mem_mem_ena;
  end

  function automatic int fat(input int a);
    return fetch_at.exists(a) ? fetch_at[a] : -1000;
  endfunction

  // ---------------- stimulus ----------------
  int          run_cyc;
  int          n_acc;
  int          t;
  logic [15:0] exp_wa [4] = '{16'h0008, 16'h0041, 16'h0009, 16'h000A};
  logic [15:0] exp_wd [4] = '{16'h0000, 16'h8001, 16'hFFFE, 16'h0001};

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    mem_arr[16'h0008] = 16'hDEAD;
    mem_arr[16'h0009] = 16'hDEAD;
    mem_arr[16'h000A] = 16'hDEAD;
    mem_arr[16'h001F] = 16'h0040;
    mem_arr[16'h0040] = 16'h8001;
    mem_arr[16'h0042] = 16'hBEEF;
    mem_arr[16'h0020] = 16'h1265; // ADD R1,R1,#5
    mem_arr[16'h0021] = 16'h0201; // BRp +1
    mem_arr[16'h0022] = 16'h720F; // skipped marker
    mem_arr[16'h0023] = 16'h127B; // ADD R1,R1,#-5
    mem_arr[16'h0024] = 16'h0401; // BRz +1
    mem_arr[16'h0025] = 16'h720F;
    mem_arr[16'h0026] = 16'h7208; // STR R1,R0,#8
    mem_arr[16'h0027] = 16'h0A01; // BRnp +1 (not taken)
    mem_arr[16'h0028] = 16'h8000; // unsupported -> NOP
    mem_arr[16'h0029] = 16'h661F; // LDR R3,R0,#31
    mem_arr[16'h002A] = 16'h64C0; // LDR R2,R3,#0
    mem_arr[16'h002B] = 16'h0801; // BRn +1
    mem_arr[16'h002C] = 16'h720F;
    mem_arr[16'h002D] = 16'h74C1; // STR R2,R3,#1
    mem_arr[16'h002E] = 16'h58A0; // AND R4,R2,#0
    mem_arr[16'h002F] = 16'h9B3F; // NOT R5,R4
    mem_arr[16'h0030] = 16'h1D45; // ADD R6,R5,R5
    mem_arr[16'h0031] = 16'h7C09; // STR R6,R0,#9
    mem_arr[16'h0032] = 16'hC140; // JMP R5
    mem_arr[16'hFFFF] = 16'h0403; // BRz +3 (not taken, PC wraps)
    mem_arr[16'h0000] = 16'h4802; // JSR +2
    mem_arr[16'h0001] = 16'h720F;
    mem_arr[16'h0002] = 16'h720F;
    mem_arr[16'h0003] = 16'h7E0A; // STR R7,R0,#10
    mem_arr[16'h0004] = 16'hD123; // PSE
    mem_arr[16'h0005] = 16'h74C2; // STR R2,R3,#2 (never ready)

    reset      = 1'b0;
    run_i      = 1'b0;
    continue_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_halted", halted_o, 1);
    check("rst_ena", bus.mem_mem_ena, 0);
    check("rst_wr", bus.mem_wr_ena, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_hex", hex_display_debug, 0);
    check("rst_led", led_o, 0);
    repeat (3) @(negedge clk);
    check("halt_idle", halted_o, 1);
    check("halt_no_acc", acc_addr.size(), 0);

    run_i   = 1'b1;
    run_cyc = cyc;
    @(negedge clk);
    run_i = 1'b0;

    t = 0;
    while (led_o == 16'h0000 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("pause_reached", t < 2000, 1);

    check("first_addr", acc_addr[0], 16'h0020);
    check("first_lat", fat(16'h20) - run_cyc, 2);
    check("add_cycles", fat(16'h21) - fat(16'h20), 5);
    check("ir_after_fetch", fetch_hex.exists(16'h21) ? fetch_hex[16'h21] : 16'hxxxx, 16'h1265);
    check("brp_skip", fetch_at.exists(16'h22), 0);
    check("brp_target", fat(16'h23) - fat(16'h21), 5);
    check("brz_skip", fetch_at.exists(16'h25), 0);
    check("brz_target", fetch_at.exists(16'h26), 1);
    check("brnp_fallthru", fetch_at.exists(16'h28), 1);
    check("nop_next", fetch_at.exists(16'h29), 1);
    check("ldr_cycles", fat(16'h2B) - fat(16'h2A), 13);
    check("brn_skip", fetch_at.exists(16'h2C), 0);
    check("str_cycles", fat(16'h2E) - fat(16'h2D), 13);
    check("jmp_ffff", fetch_at.exists(16'hFFFF), 1);
    check("pc_wrap", fetch_at.exists(16'h0000), 1);
    check("jsr_skip", fetch_at.exists(16'h0001), 0);
    check("jsr_target", fetch_at.exists(16'h0003), 1);
    check("wr_count", w_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_addr%0d", i), w_addr[i], exp_wa[i]);
      check($sformatf("wr_data%0d", i), w_data[i], exp_wd[i]);
    end

    check("pause_led", led_o, 16'h0123);
    check("pause_hex", hex_display_debug, 16'hD123);
    n_acc = acc_addr.size();
    repeat (6) @(negedge clk);
    check("pause_held_led", led_o, 16'h0123);
    check("pause_held_acc", acc_addr.size(), n_acc);
    continue_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pause_release", led_o, 16'h0123);
    continue_i = 1'b1;
    t = 0;
    while (acc_addr.size() == n_acc && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("resume_seen", t < 20, 1);
    check("resume_addr", acc_addr[n_acc], 16'h0005);
    check("resume_led", led_o, 0);

    t = 0;
    while (!(bus.mem_mem_ena && bus.mem_wr_ena) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("str_pending", t < 50, 1);
    check("str_pend_addr", bus.mem_addr, 16'h0042);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst2_halted", halted_o, 1);
    check("rst2_ena", bus.mem_mem_ena, 0);
    check("rst2_wr", bus.mem_wr_ena, 0);
    check("rst2_addr", bus.mem_addr, 0);
    check("rst2_wdata", bus.mem_wdata, 0);
    check("rst2_hex", hex_display_debug, 0);
    repeat (4) @(negedge clk);
    check("rst2_no_write", w_addr.size(), 4);
    check("rst2_mem42", mem_arr[16'h0042], 16'hBEEF);
    check("rst2_idle", bus.mem_mem_ena, 0);
    check("ena_held", hold_viol, 0);
    check("wr_only_with_ena", wr_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slc3_mc_core.md
# slc3_mc_core

Parametrised multi-cycle SLC-3 core: fetch/decode/execute state machine, 8×16 register file, N/Z/P condition codes and branch enable, driving a variable-latency memory port with a ready handshake. It replaces the fixed-timing core. It adds configurable reset PC, address width and wait-state memory access. It also adds a run/pause/continue debug protocol. It sits between the top-level switch/button synchroniser and the memory/IO subsystem.

## Interface
- PC_RESET, 16'h0000, PC value loaded by reset
- ADDR_W, 16, width of mem_addr (MAR[ADDR_W-1:0]; upper MAR bits ignored), range 8..16
- PAUSE_EN, 1, 1 = opcode 1101 is PSE (pause); 0 = opcode 1101 executes as NOP
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; one clock; no async paths
- run_i  in  1  level, pre-synchronised; starts execution from HALT
- continue_i  in  1  level, pre-synchronised; released-then-pressed (rising edge) resumes from PAUSE
- mem_rdata  in  16  read data, valid when mem_ready=1
- mem_ready  in  1  memory completes current access this cycle
- mem_wdata  out  16  = MDR
- mem_addr  out  ADDR_W  = MAR[ADDR_W-1:0]
- mem_mem_ena  out  1  access request, held until mem_ready
- mem_wr_ena  out  1  write qualifier, only with mem_mem_ena
- hex_display_debug  out  16  = IR
- led_o  out  16  PAUSE: {4'b0, IR[11:0]}; else 16'h0000
- halted_o  out  1  1 in HALT state

## Operation
- ISA subset: ADD/AND (reg and imm5), NOT, BR, JMP, JSR (PCoffset11), LDR, STR, PSE; unsupported opcodes = NOP (return to FETCH1, no state change).
- States: HALT, FETCH1 (MAR←PC, PC←PC+1), FETCH2 (read, MDR←mem_rdata on ready), FETCH3 (IR←MDR), DECODE (BEN←(n&IR[11])|(z&IR[10])|(p&IR[9])), execute states per opcode, PAUSE.
- Execute: ADD/AND/NOT: DR←ALU, CC set, →FETCH1. BR: if BEN, PC←PC+SEXT(IR[8:0]). JMP: PC←R[IR[8:6]]. JSR: R7←PC, PC←PC+SEXT(IR[10:0]). LDR: MAR←BaseR+SEXT(IR[5:0]); read; DR←MDR, CC set. STR: MAR←addr, MDR←R[IR[11:9]]; write.
- CC: n/z/p one-hot from value written to DR; only ADD/AND/NOT/LDR update CC.
- Memory: mem_mem_ena asserted for entire FETCH2/read/write state; transfer completes in first cycle mem_ready=1 (zero-wait allowed: ready same cycle as request). mem_wr_ena=1 only in STR write state. mem_ready ignored when mem_mem_ena=0.
- HALT→FETCH1 when run_i=1. PSE (PAUSE_EN=1): enter PAUSE; leave to FETCH1 on continue_i rising edge (edge detector registered; continue_i held high on entry does not resume).
- Arithmetic: 16-bit two's complement, wrap-around, no overflow flag. PC+1 wraps FFFF→0000.
- Branch/JMP/JSR target computed from incremented PC.
- Reset (reset=0 at clk edge): state HALT; PC←PC_RESET; IR, MAR, MDR, R0–R7 ←0; n=0,z=1,p=0; BEN=0; continue edge register←1. Outputs after reset: mem_mem_ena=0, mem_wr_ena=0, mem_addr=0, mem_wdata=0, hex_display_debug=0, led_o=0, halted_o=1.
- Reset mid-access overrides everything; in-flight memory transaction abandoned, no write completes after reset edge.

## Timing
- W = wait cycles (mem_ready low) per access. Fetch = 3+W cycles (FETCH1..FETCH3), DECODE 1.
- ADD/AND/NOT/BR/JMP/JSR: 5+W cycles total per instruction.
- LDR: 7+2W (addr, read 1+W, load). STR: 7+2W (addr/data, write 1+W).
- Register write and CC update visible on the edge ending the execute state; next fetch sees new PC.
- run_i sampled every cycle in HALT; first mem_mem_ena two cycles after run_i seen (HALT→FETCH1→FETCH2).

## Test plan
- Reset with reset=0 one cycle, PC_RESET=16'h0020 -> halted_o=1, all mem outputs 0; after run_i=1, first mem_addr=0x0020 with mem_mem_ena=1.
- Memory 0x0000: ADD R1,R1,#5; ADD R1,R1,#-5, W=0 -> R1=5 then 0, CC p then z; second instruction completes cycle 10 after run.
- W=3 random ready delays, mem_mem_ena held throughout -> LDR R2 from 0x0040=16'h8001 gives R2=16'h8001, n=1; 13 cycles for LDR.
- STR R2,[R3=0x0040,#1] -> one write cycle, mem_addr=0x0041, mem_wdata=16'h8001, mem_wr_ena=1 only that access.
- BRz taken/not-taken and PC 0xFFFF wrap -> PC=target when z=1, else fetch continues at wrapped PC 0x0000.
- PSE 0xD123 with continue_i already high -> stays PAUSE, led_o=16'h0123; drop then raise continue_i -> resumes FETCH1; reset asserted during pending STR write -> no write issued.
